// File: rtl/blk_chk_pkg.sv
// Shared definitions for the keyword-checker scheduler: FSM encoding, widths
// and the keyword constants the external checker recognises.
package blk_chk_pkg;

    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Keywords understood by the shared checker; words are space-separated.
    localparam logic [39:0]       KW_BEGIN = "begin";
    localparam logic [23:0]       KW_END   = "end";
    localparam logic [CHAR_W-1:0] KW_SEP   = " ";

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/block_check_sched.sv
// Shares one keyword checker between two requesters, one whole message at a
// time, and returns verdict, length and saturation per message.
module block_check_sched
    import blk_chk_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [CHAR_W-1:0]  req_char0,
    input  logic [CHAR_W-1:0]  req_char1,
    input  logic [NUM_REQ-1:0] req_last,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               chk_clear,
    output logic               chk_valid,
    output logic [CHAR_W-1:0]  chk_char,
    input  logic               chk_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic               rsp_result,
    output logic [LEN_W-1:0]   rsp_len,
    output logic               rsp_sat
);

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    state_t             r_state;
    state_t             w_next;
    logic               r_grant;
    logic               r_last;
    logic               r_clear;
    logic [LEN_W-1:0]   r_len;
    logic               r_sat;
    logic               r_rsp_id;
    logic               r_rsp_result;
    logic [LEN_W-1:0]   r_rsp_len;
    logic               r_rsp_sat;
    logic               w_arb_grant;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [CHAR_W-1:0]  w_sel_char;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_chk_valid;
    logic [CHAR_W-1:0]  w_chk_char;

    rr_arb2 u_arb (
        .req   (req_valid),
        .last  (r_last),
        .grant (w_arb_grant)
    );

    assign w_sel_valid = r_grant ? req_valid[1] : req_valid[0];
    assign w_sel_last  = r_grant ? req_last[1]  : req_last[0];
    assign w_sel_char  = r_grant ? req_char1    : req_char0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus the streaming path, which must follow the granted requester combinationally.
    always_comb begin
        w_next      = r_state;
        w_ready     = '0;
        w_chk_valid = 1'b0;
        w_chk_char  = '0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_next = ST_STREAM;
            end
            ST_STREAM: begin
                w_ready     = r_grant ? 2'b10 : 2'b01;
                w_chk_valid = w_sel_valid;
                w_chk_char  = w_sel_char;
                if (w_sel_valid && w_sel_last) begin
                    w_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Grant is frozen for the whole message; last-grant moves only once the response is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            if (r_state == ST_IDLE && |req_valid) begin
                r_grant <= w_arb_grant;
            end
            if (r_state == ST_RESP && rsp_ready) begin
                r_last <= r_grant;
            end
        end
    end

    // Checker clear is held through reset so an abandoned message leaves no residue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clear <= 1'b1;
        end else begin
            r_clear <= (w_next == ST_CLEAR);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len <= '0;
            r_sat <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_len <= '0;
            r_sat <= 1'b0;
        end else if (w_chk_valid) begin
            if (r_len == LEN_MAX) begin
                r_sat <= 1'b1;
            end else begin
                r_len <= r_len + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 1'b0;
            r_rsp_len    <= '0;
            r_rsp_sat    <= 1'b0;
        end else if (r_state == ST_SAMPLE) begin
            r_rsp_id     <= r_grant;
            r_rsp_result <= chk_result;
            r_rsp_len    <= r_len;
            r_rsp_sat    <= r_sat;
        end
    end

    assign req_ready  = w_ready;
    assign chk_valid  = w_chk_valid;
    assign chk_char   = w_chk_char;
    assign chk_clear  = r_clear;
    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_len    = r_rsp_len;
    assign rsp_sat    = r_rsp_sat;

endmodule

// File: tb/tb_block_check_sched.sv
// Directed bench for block_check_sched with a behavioural keyword checker;
// a second LEN_W=4 instance shadows the main one for saturation.
module tb_block_check_sched;
    import blk_chk_pkg::*;

    localparam int BUDGET = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic       v0, v1, l0, l1;
    logic [7:0] c0, c1;
    logic [1:0] req_valid, req_last;
    logic       rsp_ready;

    logic [1:0]  req_ready, req_ready_4;
    logic        chk_clear, chk_valid, chk_result;
    logic [7:0]  chk_char;
    logic        rsp_valid, rsp_id, rsp_result, rsp_sat;
    logic [15:0] rsp_len;
    logic        chk_clear_4, chk_valid_4, rsp_valid_4, rsp_id_4, rsp_result_4, rsp_sat_4;
    logic [7:0]  chk_char_4;
    logic [3:0]  rsp_len_4;

    assign req_valid = {v1, v0};
    assign req_last  = {l1, l0};

    always #5 clk = ~clk;

    block_check_sched #(.LEN_W(16)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_char0(c0), .req_char1(c1),
        .req_last(req_last), .req_ready(req_ready), .chk_clear(chk_clear), .chk_valid(chk_valid),
        .chk_char(chk_char), .chk_result(chk_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_len(rsp_len), .rsp_sat(rsp_sat)
    );

    block_check_sched #(.LEN_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_char0(c0), .req_char1(c1),
        .req_last(req_last), .req_ready(req_ready_4), .chk_clear(chk_clear_4), .chk_valid(chk_valid_4),
        .chk_char(chk_char_4), .chk_result(1'b1), .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id_4), .rsp_result(rsp_result_4), .rsp_len(rsp_len_4), .rsp_sat(rsp_sat_4)
    );

    // Behavioural checker: balanced when no unmatched "end" and depth is zero.
    int          m_depth = 0;
    bit          m_bad   = 1'b0;
    logic [39:0] m_word  = '0;
    int          m_wlen  = 0;

    always @(posedge clk) begin
        if (chk_clear) begin
            m_depth = 0; m_bad = 1'b0; m_word = '0; m_wlen = 0;
        end else if (chk_valid) begin
            if (chk_char == KW_SEP) begin
                if (m_wlen == 5 && m_word == KW_BEGIN) begin
                    m_depth++;
                end else if (m_wlen == 3 && m_word[23:0] == KW_END) begin
                    if (m_depth == 0) m_bad = 1'b1;
                    else m_depth--;
                end
                m_word = '0; m_wlen = 0;
            end else begin
                m_word = {m_word[31:0], chk_char};
                m_wlen++;
            end
        end
    end
    assign chk_result = (m_depth == 0) && !m_bad;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_clear, n_strobe, n_div;
    int first_strobe_cyc, last_strobe_cyc, rsp_rise_cyc;
    logic prev_rsp_valid = 1'b0;
    int q_id[$], q_res[$], q_len[$], q_sat[$], q_len4[$], q_sat4[$], q_res4[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_clear && !reset) n_clear++;
        if (chk_valid) begin
            n_strobe++;
            if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
            last_strobe_cyc = cyc;
        end
        if (rsp_valid && !prev_rsp_valid) rsp_rise_cyc = cyc;
        prev_rsp_valid = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            q_id.push_back(int'(rsp_id));
            q_res.push_back(int'(rsp_result));
            q_len.push_back(int'(rsp_len));
            q_sat.push_back(int'(rsp_sat));
        end
        if (rsp_valid_4 && rsp_ready) begin
            q_len4.push_back(int'(rsp_len_4));
            q_sat4.push_back(int'(rsp_sat_4));
            q_res4.push_back(int'(rsp_result_4));
        end
        if (!reset && ({req_ready_4, chk_valid_4, chk_char_4, chk_clear_4, rsp_valid_4, rsp_id_4} !==
                       {req_ready, chk_valid, chk_char, chk_clear, rsp_valid, rsp_id}))
            n_div++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_clear = 0; n_strobe = 0;
        first_strobe_cyc = -1; last_strobe_cyc = -1; rsp_rise_cyc = -1;
        q_id.delete(); q_res.delete(); q_len.delete(); q_sat.delete();
        q_len4.delete(); q_sat4.delete(); q_res4.delete();
    endtask

    task automatic set_req(input int id, input logic v, input logic [7:0] c, input logic l);
        if (id == 0) begin v0 = v; c0 = c; l0 = l; end
        else         begin v1 = v; c1 = c; l1 = l; end
    endtask

    // Sends s from requester id; gap_mask bit i inserts a 2-cycle idle gap before char i,
    // stop_after >= 0 abandons the message after that many accepted chars.
    task automatic send_msg(input int id, input string s, input logic [31:0] gap_mask, input int stop_after);
        for (int i = 0; i < s.len(); i++) begin
            int t;
            if (i == stop_after) begin
                set_req(id, 1'b0, 8'h00, 1'b0);
                return;
            end
            if (gap_mask[i]) begin
                set_req(id, 1'b0, 8'h00, 1'b0);
                repeat (2) @(posedge clk);
                #1;
            end
            set_req(id, 1'b1, s[i], (i == s.len() - 1));
            t = 0;
            forever begin
                @(negedge clk);
                if (req_ready[id[0]]) break;
                t++;
                if (t > BUDGET) begin
                    check_eq("accept_timeout", 32'(t), 32'd0);
                    set_req(id, 1'b0, 8'h00, 1'b0);
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        set_req(id, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_rsp(input int n);
        int t = 0;
        while (q_id.size() < n && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        check_eq("rsp_wait", 32'(q_id.size()), 32'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear_stats();
    endtask

    initial begin
        int t;
        n_div = 0;
        reset = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        clear_stats();
        #1 reset = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_clear", 32'(chk_clear), 32'd1);
        check_eq("rst_outs", 32'({req_ready, chk_valid, chk_char, rsp_valid, rsp_id, rsp_result, rsp_sat}), 32'd0);
        check_eq("rst_len", 32'(rsp_len), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst_outs", 32'({chk_clear, req_ready, chk_valid, chk_char, rsp_valid, rsp_sat}), 32'd0);
        clear_stats();

        // Req0 "begin end " with timing
        t = cyc;
        send_msg(0, "begin end ", 32'h0, -1);
        wait_rsp(1);
        check_eq("t1_clear_pulses", 32'(n_clear), 32'd1);
        check_eq("t1_strobes", 32'(n_strobe), 32'd10);
        check_eq("t1_id", 32'(q_id[0]), 32'd0);
        check_eq("t1_len", 32'(q_len[0]), 32'd10);
        check_eq("t1_result", 32'(q_res[0]), 32'd1);
        check_eq("t1_sat", 32'(q_sat[0]), 32'd0);
        check_eq("t1_req_to_accept", 32'(first_strobe_cyc - t), 32'd2);
        check_eq("t1_last_to_rsp", 32'(rsp_rise_cyc - last_strobe_cyc), 32'd2);
        clear_stats();

        // Req1 "end " is unbalanced
        send_msg(1, "end ", 32'h0, -1);
        wait_rsp(1);
        check_eq("t2_id", 32'(q_id[0]), 32'd1);
        check_eq("t2_len", 32'(q_len[0]), 32'd4);
        check_eq("t2_result", 32'(q_res[0]), 32'd0);
        clear_stats();

        // Single-character message
        send_msg(0, " ", 32'h0, -1);
        wait_rsp(1);
        check_eq("t2b_len", 32'(q_len[0]), 32'd1);
        check_eq("t2b_result", 32'(q_res[0]), 32'd1);
        clear_stats();

        // Gaps and back-pressured response
        rsp_ready = 1'b0;
        send_msg(0, "begin end ", 32'h0000_00A4, -1);
        t = 0;
        while (!rsp_valid && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("t3_hold%0d", k),
                     32'({rsp_valid, rsp_id, rsp_result, rsp_sat, rsp_len}),
                     32'({1'b1, 1'b0, 1'b1, 1'b0, 16'd10}));
            if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("t3_idle_after_hs", 32'({rsp_valid, req_ready}), 32'd0);
        check_eq("t3_strobes", 32'(n_strobe), 32'd10);
        check_eq("t3_rsp_count", 32'(q_id.size()), 32'd1);
        @(posedge clk);
        #1;
        clear_stats();

        // 20 chars: LEN_W=4 instance saturates
        send_msg(0, "begin begin end end ", 32'h0, -1);
        wait_rsp(1);
        check_eq("t4_len16", 32'(q_len[0]), 32'd20);
        check_eq("t4_sat16", 32'(q_sat[0]), 32'd0);
        check_eq("t4_result", 32'(q_res[0]), 32'd1);
        check_eq("t4_len4", 32'(q_len4.size() > 0 ? q_len4[0] : -1), 32'd15);
        check_eq("t4_sat4", 32'(q_sat4.size() > 0 ? q_sat4[0] : -1), 32'd1);
        check_eq("t4_res4", 32'(q_res4.size() > 0 ? q_res4[0] : -1), 32'd1);

        // Simultaneous requests after reset, then a re-contested IDLE
        do_reset();
        fork
            begin
                send_msg(0, "begin ", 32'h0, -1);
                send_msg(0, "begin end ", 32'h0, -1);
            end
            send_msg(1, "end ", 32'h0, -1);
        join
        wait_rsp(3);
        check_eq("t5_id0", 32'(q_id[0]), 32'd0);
        check_eq("t5_id1", 32'(q_id[1]), 32'd1);
        check_eq("t5_id2", 32'(q_id[2]), 32'd0);
        check_eq("t5_len0", 32'(q_len[0]), 32'd6);
        check_eq("t5_len1", 32'(q_len[1]), 32'd4);
        check_eq("t5_res2", 32'(q_res[2]), 32'd1);
        clear_stats();

        // Reset mid-message
        send_msg(0, "begin end ", 32'h0, 3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("t6_clear_in_rst", 32'(chk_clear), 32'd1);
        check_eq("t6_outs_in_rst", 32'({rsp_valid, req_ready, chk_valid}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("t6_no_rsp", 32'(q_id.size()), 32'd0);
        check_eq("t6_strobes_before", 32'(n_strobe), 32'd3);
        clear_stats();
        send_msg(0, "begin end ", 32'h0, -1);
        wait_rsp(1);
        check_eq("t6_resend_result", 32'(q_res[0]), 32'd1);
        check_eq("t6_resend_len", 32'(q_len[0]), 32'd10);

        check_eq("shadow_divergence", 32'(n_div), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/block_check_sched.md
BLOCK_CHECK_SCHED -- requirements
Module: block_check_sched

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the per-message character counter.
REQ-002 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req_valid[1:0]  in  2  per-requester character valid.
REQ-005 SHALL have ports req_char0, req_char1  in  8 each  ASCII character from requester 0/1.
REQ-006 SHALL have ports req_last[1:0]  in  2  marks the final character of a message.
REQ-007 SHALL have port req_ready[1:0]  out  2  character accepted when valid&ready.
REQ-008 SHALL have ports chk_clear  out  1, chk_valid  out  1, chk_char  out  8  (clear pulse, character strobe and character to the shared keyword checker).
REQ-009 SHALL have port chk_result  in  1  checker verdict (1 = begin/end balanced so far).
REQ-010 SHALL have ports rsp_valid  out  1, rsp_ready  in  1, rsp_id  out  1, rsp_result  out  1, rsp_len  out  LEN_W, rsp_sat  out  1.

Function
REQ-011 SHALL share one checker between two requesters at message granularity; no interleaving of characters from different messages.
REQ-012 SHALL implement states IDLE, CLEAR, STREAM, SAMPLE, RESP.
REQ-013 IDLE: SHALL move to CLEAR when any req_valid is 1, latching grant g from the round-robin arbiter.
REQ-014 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset, requester 0 has priority.
REQ-015 CLEAR: SHALL assert chk_clear for exactly one cycle, clear the length counter, then enter STREAM.
REQ-016 STREAM: req_ready[g] SHALL be 1 and req_ready[!g] SHALL be 0; req_ready SHALL be 0 in all other states.
REQ-017 STREAM: chk_valid SHALL equal req_valid[g], and chk_char SHALL equal req_char of g, combinationally; chk_valid SHALL be 0 outside STREAM.
REQ-018 Each accepted character SHALL increment the length counter, saturating at 2^LEN_W-1 and setting a sticky saturation flag.
REQ-019 Acceptance with req_last[g]=1 SHALL move to SAMPLE; gaps (req_valid[g]=0) SHALL hold STREAM indefinitely.
REQ-020 SAMPLE: SHALL register chk_result into rsp_result, g into rsp_id, counter into rsp_len, flag into rsp_sat, then enter RESP.
REQ-021 RESP: rsp_valid SHALL be 1 and response fields stable until rsp_valid&rsp_ready; then SHALL update last-grant to g and return to IDLE.
REQ-022 Minimum turnaround SHALL be: request seen in IDLE -> first accept 2 cycles later -> rsp_valid 2 cycles after the last-character accept.
REQ-023 A single-character message (req_last on first character) SHALL be legal and follow the same sequence.
REQ-024 req_valid of the non-granted requester SHALL be ignored until the current response completes.

Reset
REQ-025 Reset SHALL force IDLE, last-grant = 1 (requester 0 favoured), counter 0, flag 0.
REQ-026 During and after reset, outputs SHALL be 0: req_ready, chk_valid, chk_char, rsp_valid, rsp_id, rsp_result, rsp_len, rsp_sat. chk_clear SHALL be 1 while reset is asserted, so the checker is cleared.
REQ-027 Reset asserted mid-message SHALL abandon the message with no response; the requester restarts the message.

Structure
REQ-028 State encoding and the keyword constants SHALL reside in the shared package blk_chk_pkg.
REQ-029 Round-robin selection SHALL be the sub-module rr_arb2 (inputs req[1:0], last; output grant).
REQ-030 Keyword detection SHALL remain in the checker; this block SHALL contain no character decoding.

Verification
REQ-031 Req0 sends "begin end " (last on final space), rsp_ready=1 -> chk_clear one pulse, 10 chk_valid strobes, rsp_id=0, rsp_len=10, rsp_result=1.
REQ-032 Req0 and req1 both raise valid in the same IDLE cycle after reset -> req0 served first, then req1; repeat -> req1 first.
REQ-033 Req1 sends "end " -> rsp_result=0, rsp_len=4, rsp_id=1.
REQ-034 Req0 message with 3 idle gaps, rsp_ready held 0 for 5 cycles -> no extra chk_valid, rsp fields stable 5 cycles, IDLE one cycle after handshake.
REQ-035 LEN_W=4, 20-character message -> rsp_len=15, rsp_sat=1.
REQ-036 Reset asserted after 3 characters of a message -> no rsp_valid, chk_clear=1 while reset is asserted, the resent message returns a correct result.
